// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, pointer-width helper and level type for the FIFO family
package fifo_pkg;
  localparam int FIFO_STD = 0;
  localparam int FIFO_FWFT = 1;
  localparam int MAX_DEPTH_WIDTH = 16;
  typedef logic [MAX_DEPTH_WIDTH:0] level_t;
  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction
endpackage

// File: rtl/fifo_fwft_stage.sv
// fifo_fwft_stage: head-word valid tracking and RAM prefetch control for FWFT mode;
// the RAM's registered read port serves as the one-entry output register
module fifo_fwft_stage #(
  parameter int PW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] wptr,
  input  logic          rd_en,
  output logic [PW-1:0] rptr,
  output logic          re,
  output logic          empty
);
  logic valid;
  logic pop;
  assign pop = rd_en && valid;
  assign re = (!valid || pop) && (wptr != rptr);
  assign empty = !valid;
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      rptr <= '0;
    end else begin
      valid <= re || (valid && !pop);
      rptr <= rptr + PW'(re);
    end
endmodule

// File: rtl/simple_dpram_sclk.sv
// simple_dpram_sclk: single-clock simple dual-port RAM with registered read port
module simple_dpram_sclk #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter string ENABLE_BYPASS = "TRUE"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= din;
  always_ff @(posedge clk)
    if (rst) dout <= '0;
    else if (re) dout <= (ENABLE_BYPASS == "TRUE" && we && waddr == raddr) ? din : mem[raddr];
endmodule

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with optional FWFT output, fill level,
// programmable almost-full/almost-empty flags and overflow/underflow pulses
module sync_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FWFT = 0,
  parameter int AFULL_THRESH = (1 << DEPTH_WIDTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [DEPTH_WIDTH:0]   level_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int PW = ptr_width(DEPTH_WIDTH);
  localparam int LW = DEPTH_WIDTH + 1;
  if (DEPTH_WIDTH < 1 || DEPTH_WIDTH > MAX_DEPTH_WIDTH || DATA_WIDTH < 1 ||
      (FWFT != FIFO_STD && FWFT != FIFO_FWFT) || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_params
    $error("sync_fifo_lvl: parameter out of range");
  end
  logic [PW-1:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic wr_acc, rd_acc, re;
  assign wr_acc = wr_en_i && !full_o;
  assign rd_acc = rd_en_i && !empty_o;
  assign full_o = level_o == LW'(DEPTH);
  assign almost_full_o = level_t'(level_o) >= level_t'(AFULL_THRESH);
  assign almost_empty_o = level_t'(level_o) <= level_t'(AEMPTY_THRESH);
  assign rd_data_o = ram_dout;
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      level_o <= '0;
      overflow_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      wptr <= wptr + PW'(wr_acc);
      level_o <= level_o + LW'(wr_acc) - LW'(rd_acc);
      overflow_o <= wr_en_i && full_o;
      underflow_o <= rd_en_i && empty_o;
    end
  simple_dpram_sclk #(
    .ADDR_WIDTH(DEPTH_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ENABLE_BYPASS("FALSE")
  ) u_ram (
    .clk(clk),
    .rst(rst),
    .raddr(rptr[DEPTH_WIDTH-1:0]),
    .re(re),
    .waddr(wptr[DEPTH_WIDTH-1:0]),
    .we(wr_acc),
    .din(wr_data_i),
    .dout(ram_dout)
  );
  if (FWFT == FIFO_FWFT) begin : g_fwft
    fifo_fwft_stage #(.PW(PW)) u_stage (
      .clk(clk),
      .rst(rst),
      .wptr(wptr),
      .rd_en(rd_en_i),
      .rptr(rptr),
      .re(re),
      .empty(empty_o)
    );
  end else begin : g_std
    // equal pointers including the wrap bit is exactly level == 0
    assign empty_o = wptr == rptr;
    assign re = rd_acc;
    always_ff @(posedge clk)
      if (rst) rptr <= '0;
      else rptr <= rptr + PW'(rd_acc);
  end
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: directed checks of standard, FWFT and threshold FIFO variants
module tb_sync_fifo_lvl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;

  logic [7:0] wd0, rd0;
  logic we0 = 0, re0 = 0, f0, e0, af0, ae0, ov0, un0;
  logic [2:0] lv0;
  logic [7:0] wd1, rd1;
  logic we1 = 0, re1 = 0, f1, e1, af1, ae1, ov1, un1;
  logic [3:0] lv1;
  logic [7:0] wd2, rd2;
  logic we2 = 0, re2 = 0, f2, e2, af2, ae2, ov2, un2;
  logic [3:0] lv2;

  sync_fifo_lvl #(.DEPTH_WIDTH(2), .DATA_WIDTH(8), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wr_data_i(wd0), .wr_en_i(we0), .rd_en_i(re0), .rd_data_o(rd0),
    .full_o(f0), .empty_o(e0), .almost_full_o(af0), .almost_empty_o(ae0), .level_o(lv0),
    .overflow_o(ov0), .underflow_o(un0));
  sync_fifo_lvl #(.DEPTH_WIDTH(3), .DATA_WIDTH(8), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wr_data_i(wd1), .wr_en_i(we1), .rd_en_i(re1), .rd_data_o(rd1),
    .full_o(f1), .empty_o(e1), .almost_full_o(af1), .almost_empty_o(ae1), .level_o(lv1),
    .overflow_o(ov1), .underflow_o(un1));
  sync_fifo_lvl #(.DEPTH_WIDTH(3), .DATA_WIDTH(8), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u2 (
    .clk(clk), .rst(rst), .wr_data_i(wd2), .wr_en_i(we2), .rd_en_i(re2), .rd_data_o(rd2),
    .full_o(f2), .empty_o(e2), .almost_full_o(af2), .almost_empty_o(ae2), .level_o(lv2),
    .overflow_o(ov2), .underflow_o(un2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wd0 = 0; wd1 = 0; wd2 = 0;
    tick(); tick();
    check("rst_level", lv0, 0);
    check("rst_empty", e0, 1);
    check("rst_full", f0, 0);
    check("rst_aempty", ae0, 1);
    check("rst_afull", af0, 0);
    check("rst_ovf", ov0, 0);
    check("rst_unf", un0, 0);
    check("rst_data", rd0, 0);
    check("rst_fwft_empty", e1, 1);
    check("rst_fwft_data", rd1, 0);
    rst = 0;
    // standard mode: fill, overflow, drain
    we0 = 1;
    for (int i = 1; i <= 4; i++) begin
      wd0 = 8'(i);
      tick();
    end
    check("std_full", f0, 1);
    check("std_level4", lv0, 4);
    check("std_afull", af0, 1);
    wd0 = 8'd5;
    tick();
    check("std_ovf_pulse", ov0, 1);
    check("std_ovf_level", lv0, 4);
    we0 = 0;
    tick();
    check("std_ovf_once", ov0, 0);
    re0 = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("std_rd_data", rd0, 64'(i));
    end
    re0 = 0;
    check("std_empty", e0, 1);
    check("std_level0", lv0, 0);
    re0 = 1;
    tick();
    check("unf_pulse", un0, 1);
    check("unf_level", lv0, 0);
    check("unf_data_hold", rd0, 4);
    re0 = 0;
    tick();
    check("unf_once", un0, 0);
    // FWFT: single write falls through after two cycles
    we1 = 1; wd1 = 8'hA5;
    tick();
    we1 = 0;
    check("fwft_n1_level", lv1, 1);
    check("fwft_n1_empty", e1, 1);
    tick();
    check("fwft_n2_empty", e1, 0);
    check("fwft_n2_data", rd1, 8'hA5);
    re1 = 1;
    tick();
    re1 = 0;
    check("fwft_pop_empty", e1, 1);
    check("fwft_pop_level", lv1, 0);
    // FWFT: hold level 3 while streaming across pointer wrap
    we1 = 1;
    for (int i = 0; i < 3; i++) begin
      wd1 = 8'(10 + i);
      tick();
    end
    we1 = 0;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      check("stream_level", lv1, 3);
      check("stream_empty", e1, 0);
      check("stream_data", rd1, 64'(10 + i));
      we1 = 1; re1 = 1; wd1 = 8'(13 + i);
      tick();
    end
    we1 = 0; re1 = 0;
    check("stream_level_end", lv1, 3);
    check("stream_data_end", rd1, 30);
    // threshold crossings on fill and drain
    we2 = 1;
    for (int i = 0; i < 8; i++) begin
      check("fill_level", lv2, 64'(i));
      check("fill_aempty", ae2, (i <= 2) ? 1 : 0);
      check("fill_afull", af2, (i >= 6) ? 1 : 0);
      wd2 = 8'(i);
      tick();
    end
    we2 = 0;
    check("fill_full", f2, 1);
    check("fill_afull8", af2, 1);
    check("fill_aempty8", ae2, 0);
    re2 = 1;
    for (int i = 8; i > 0; i--) begin
      check("drain_level", lv2, 64'(i));
      check("drain_aempty", ae2, (i <= 2) ? 1 : 0);
      check("drain_afull", af2, (i >= 6) ? 1 : 0);
      tick();
    end
    re2 = 0;
    check("drain_level0", lv2, 0);
    check("drain_aempty0", ae2, 1);
    // reset mid-operation discards contents
    we2 = 1;
    for (int i = 0; i < 5; i++) begin
      wd2 = 8'(100 + i);
      tick();
    end
    check("pre_rst_level", lv2, 5);
    rst = 1; wd2 = 8'd77;
    tick();
    rst = 0; we2 = 0;
    check("mid_rst_level", lv2, 0);
    check("mid_rst_empty", e2, 1);
    check("mid_rst_ovf", ov2, 0);
    check("mid_rst_data", rd2, 0);
    we2 = 1; wd2 = 8'h55;
    tick();
    we2 = 0; re2 = 1;
    tick();
    re2 = 0;
    check("post_rst_data", rd2, 8'h55);
    check("post_rst_empty", e2, 1);
    check("post_rst_level", lv2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_lvl.md
# sync_fifo_lvl

Single-clock parametrised FIFO. It is the successor to the team's basic store-buffer FIFO and uses all 2^DEPTH_WIDTH entries. It adds a selectable first-word-fall-through (FWFT) output mode, a fill-level count, programmable almost-full/almost-empty flags and overflow/underflow error pulses. It sits between producer and consumer pipelines in the same clock domain, such as store buffers and bus-bridge queues.

## Interface
- DEPTH_WIDTH, 4: log2 of capacity; capacity DEPTH = 2^DEPTH_WIDTH; must be ≥1.
- DATA_WIDTH, 32: entry width; must be ≥1.
- FWFT, 0: 0 = standard read latency; 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-1: almost_full_o asserts when level ≥ this value; range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty_o asserts when level ≤ this value; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_data_i  in  DATA_WIDTH  write data.
- wr_en_i  in  1  write request.
- rd_en_i  in  1  read/pop request.
- rd_data_o  out  DATA_WIDTH  read data.
- full_o  out  1  level == DEPTH.
- empty_o  out  1  no readable word.
- almost_full_o  out  1  programmable high-water flag.
- almost_empty_o  out  1  programmable low-water flag.
- level_o  out  DEPTH_WIDTH+1  number of stored words, 0..DEPTH.
- overflow_o  out  1  one-cycle pulse: write rejected.
- underflow_o  out  1  one-cycle pulse: read rejected.

## Operation
- Pointers are DEPTH_WIDTH+1 bits wide. The MSB is the wrap bit, which distinguishes full from empty, so all DEPTH entries are usable.
- A write is accepted iff wr_en_i && !full_o. It stores to RAM at wptr, and wptr increments and wraps modulo 2·DEPTH.
- A read is accepted iff rd_en_i && !empty_o.
- Rejected requests change no state.
  - A rejected write pulses overflow_o on the next cycle.
  - A rejected read pulses underflow_o on the next cycle.
- Write while full is rejected even if a read is accepted in the same cycle.
- Read while empty is rejected even if a write is accepted in the same cycle.
- Accepted read and write in the same cycle leave level_o unchanged.
- level_o: +1 per accepted write, −1 per accepted read, registered.
- almost_full_o and almost_empty_o are decoded from the level_o register.
- FWFT=0:
  - empty_o = (level_o == 0).
  - rd_data_o shows the popped word from the cycle after acceptance.
  - rd_data_o holds that word until the next accepted read, matching the existing FIFO.
- FWFT=1:
  - A one-entry output register holds the head word. rd_data_o is valid whenever empty_o = 0.
  - Prefetch from RAM runs whenever the output register is empty or is being popped, and RAM is non-empty.
  - empty_o reflects output-register occupancy.
  - level_o counts RAM words plus the output register. Total capacity is still DEPTH.
- Reset values:
  - level_o = 0, empty_o = 1, full_o = 0.
  - almost_empty_o = 1; almost_full_o = 0.
  - overflow_o = 0, underflow_o = 0.
  - rd_data_o = 0; pointers = 0; output register invalid.
- Reset mid-operation discards all contents. Requests in the reset cycle are ignored and raise no error pulses.

## Timing
- Write accepted in cycle N:
  - level_o and full_o update at N+1.
  - FWFT=0: empty_o falls at N+1.
  - FWFT=1, FIFO empty beforehand: empty_o falls and rd_data_o is valid at N+2 (RAM read latency of 1 cycle plus the output register). level_o is already 1 at N+1 while empty_o is still 1.
- Read accepted in cycle N:
  - FWFT=0: data appears on rd_data_o at N+1.
  - FWFT=1: the next word (if present) appears at N+1, giving back-to-back pops at full rate.
- Sustained throughput is 1 write and 1 read per cycle in both modes.
- No combinational path from wr_en_i or rd_en_i to any flag or to level_o.

## Structure
- Shared package fifo_pkg holds:
  - the pointer-width helper function (DEPTH_WIDTH+1);
  - the level type;
  - mode constants FIFO_STD = 0 and FIFO_FWFT = 1.
- Storage reuses the existing simple_dpram_sclk with ENABLE_BYPASS "FALSE".
- A second sub-module, fifo_fwft_stage (output register plus prefetch control), is instantiated only under a generate on FWFT=1.
- An elaboration-time check rejects out-of-range parameters.

## Test plan
- DEPTH_WIDTH=2, FWFT=0: write 1,2,3,4 -> full_o=1 and level_o=4. A 5th write -> overflow_o pulses once and level_o stays 4. Four reads return 1,2,3,4, then empty_o=1.
- Empty FIFO, rd_en_i=1 -> underflow_o pulses for 1 cycle, level_o stays 0, rd_data_o is unchanged.
- FWFT=1: single write of 0xA5 at cycle N -> empty_o=0 and rd_data_o=0xA5 at N+2, with no rd_en_i asserted.
- FWFT=1, DEPTH=8: 20 cycles of simultaneous read and write at level 3 -> level_o stays 3 and output order is preserved across pointer wrap.
- AFULL_THRESH=6, AEMPTY_THRESH=2, DEPTH=8: fill 0→8 then drain -> almost_empty_o=1 while level ≤2 and almost_full_o=1 while level ≥6, each switching exactly at the threshold crossing.
- rst asserted at level 5 with wr_en_i=1 -> next cycle level_o=0, empty_o=1, overflow_o=0; a subsequent write/read returns the new data only.
